load_store_unit: RTL and testbench

Memory-access stage sitting directly upstream of the register file write port. It takes a base register value, offset and store data from the register read ports, and computes the effective address. It runs a req/ack transaction with data memory. For loads it drives the register file's write destination, write enable and write data with the aligned, extended result. It also asserts busy so the control path stalls PC update during the access.

---
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: effective-address generation, req/ack memory handshake, load writeback.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] base_in,
  input  logic [31:0] offset_in,
  input  logic [31:0] store_data,
  input  logic [3:0]  dest_in,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWb, StAbort} state_e;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        size_q, size_d;
  logic              sign_ext_q, sign_ext_d;
  logic [3:0]        dest_q, dest_d;
  logic [1:0]        ea_lo_q, ea_lo_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_req_q, mem_req_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        wb_dest_q, wb_dest_d;
  logic [31:0]       wb_data_q, wb_data_d;

  logic [31:0] ea;
  logic [3:0]  be_launch;
  logic [31:0] wdata_launch;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  assign ea = base_in + offset_in;

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((size == 2'b01) && ea[0]) || (size[1] && (ea[1:0] != 2'b00));
`endif

  // Size 2'b11 falls into the word case.
  always_comb begin
    be_launch    = 4'b1111;
    wdata_launch = store_data;
    unique case (size)
      2'b00: begin
        be_launch    = 4'b0001 << ea[1:0];
        wdata_launch = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_launch    = 4'b0011 << {ea[1], 1'b0};
        wdata_launch = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = 8'h00;
    unique case (ea_lo_q)
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = ea_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val  = mem_rdata;
    unique case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{sign_ext_q & lane_half[15]}}, lane_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    sign_ext_d  = sign_ext_q;
    dest_d      = dest_q;
    ea_lo_d     = ea_lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    wb_en_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_load_d   = is_load;
          size_d      = size;
          sign_ext_d  = sign_ext;
          dest_d      = dest_in;
          ea_lo_d     = ea[1:0];
          mem_addr_d  = {ea[31:2], 2'b00};
          mem_be_d    = be_launch;
          mem_we_d    = !is_load;
          mem_wdata_d = wdata_launch;
          cnt_d       = '0;
          state_d     = StReq;
          mem_req_d   = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d   = StAbort;
            mem_req_d = 1'b0;
          end
`endif
        end
      end
      StReq: begin
        if (mem_ack) begin
          // An ack coinciding with the timeout still completes normally.
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (is_load_q) begin
            state_d   = StWb;
            wb_en_d   = 1'b1;
            wb_dest_d = dest_q;
            wb_data_d = load_val;
          end else begin
            state_d = StIdle;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: state_d = StIdle;
      StAbort: begin
        done_d  = 1'b1;
        fault_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      size_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      dest_q      <= 4'h0;
      ea_lo_q     <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_dest_q   <= 4'h0;
      wb_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      sign_ext_q  <= sign_ext_d;
      dest_q      <= dest_d;
      ea_lo_q     <= ea_lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign fault     = fault_q;
  assign wb_en     = wb_en_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level timeline model, per-cycle compare, random traffic.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, is_load, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] base_in, offset_in, store_data, mem_rdata;
  logic [3:0]  dest_in;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be, wb_dest;
  logic        mem_we, mem_req, busy, done, wb_en, fault;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .size(size),
    .sign_ext(sign_ext), .base_in(base_in), .offset_in(offset_in), .store_data(store_data),
    .dest_in(dest_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle, set right after each rising edge.
  bit          cmp_en = 1'b0;
  logic        exp_busy, exp_req, exp_done, exp_fault, exp_wb_en, exp_we;
  bit          exp_mem_vld;
  logic [31:0] exp_addr, exp_wdata, last_data;
  logic [3:0]  exp_be, last_dest;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("done", 32'(done), 32'(exp_done));
      check("fault", 32'(fault), 32'(exp_fault));
      check("wb_en", 32'(wb_en), 32'(exp_wb_en));
      check("wb_dest", 32'(wb_dest), 32'(last_dest));
      check("wb_data", wb_data, last_data);
      if (exp_mem_vld) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", 32'(mem_be), 32'(exp_be));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  function automatic logic [31:0] m_load(logic [31:0] rd, logic [1:0] sz, logic [1:0] lo,
                                         bit sx);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * lo[1])) & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] sz, logic [1:0] lo);
    if (sz == 2'b00) return 4'(1 << lo);
    if (sz == 2'b01) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] sd);
    if (sz == 2'b00) return {24'h0, sd[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'h0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic rq, input logic dn, input logic ft,
                         input logic we);
    exp_busy  = b;
    exp_req   = rq;
    exp_done  = dn;
    exp_fault = ft;
    exp_wb_en = we;
  endtask

  task automatic scramble();
    is_load    = 1'($urandom);
    size       = 2'($urandom);
    sign_ext   = 1'($urandom);
    base_in    = $urandom;
    offset_in  = $urandom;
    store_data = $urandom;
    dest_in    = 4'($urandom);
  endtask

  // Runs one access from an idle cycle; returns in an idle cycle ready for the next launch.
  task automatic run_txn(input bit ld, input logic [1:0] sz, input bit sx,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                         input logic [3:0] dst, input logic [31:0] rd, input int ack_dly,
                         output logic [31:0] c_wb, output int c_req, output logic c_fault,
                         output logic [31:0] c_addr, output logic [31:0] c_wdata,
                         output logic [3:0] c_be);
    logic [31:0] ea;
    bit mis, acked, aborted;
    int k;
    ea = base + off;
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = ((sz == 2'b01) && ea[0]) || (sz[1] && (ea[1:0] != 2'b00));
`endif
    c_wb = 32'h0; c_req = 0; c_fault = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0;
    start = 1'b1; is_load = ld; size = sz; sign_ext = sx; base_in = base; offset_in = off;
    store_data = sd; dest_in = dst; mem_ack = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    exp_mem_vld = 1'b0;
    step();
    scramble();
    if (mis) begin
      start = 1'($urandom);
      set_exp(1, 0, 0, 0, 0);
      c_req += int'(mem_req);
      step();
      start = 1'b0;
      set_exp(0, 0, 1, 1, 0);
      c_fault = fault;
      step();
      set_exp(0, 0, 0, 0, 0);
      return;
    end
    exp_mem_vld = 1'b1;
    exp_addr    = {ea[31:2], 2'b00};
    exp_be      = m_be(sz, ea[1:0]);
    exp_we      = !ld;
    exp_wdata   = m_wdata(sz, sd);
    k = 1;
    aborted = 1'b0;
    while (1) begin
      set_exp(1, 1, 0, 0, 0);
      start     = 1'($urandom);
      acked     = (k - 1 == ack_dly);
      mem_ack   = acked;
      mem_rdata = acked ? rd : $urandom;
      c_req += int'(mem_req);
      if (k == 1) begin
        c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be;
      end
      scramble();
      step();
      if (acked) break;
      if (k == TO) begin
        aborted = 1'b1;
        break;
      end
      k++;
    end
    exp_mem_vld = 1'b0;
    start   = 1'b0;
    mem_ack = 1'b0;
    if (aborted || !ld) begin
      set_exp(0, 0, 1, aborted, 0);
      c_fault = fault;
      step();
      mem_ack = 1'($urandom);
      set_exp(0, 0, 0, 0, 0);
      step();
      mem_ack = 1'b0;
    end else begin
      last_dest = dst;
      last_data = m_load(rd, sz, ea[1:0], sx);
      set_exp(1, 0, 1, 0, 1);
      c_wb    = wb_data;
      c_fault = fault;
      start   = 1'($urandom);
      mem_ack = 1'($urandom);
      step();
      start   = 1'b0;
      mem_ack = 1'b0;
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    logic [31:0] wb, a, wd;
    logic [3:0]  be;
    logic        ft;
    int          nreq;
    bit          ld;
    logic [1:0]  sz;
    int          dly;

    reset = 1'b1; start = 1'b0; is_load = 1'b0; size = 2'b00; sign_ext = 1'b0;
    base_in = 32'h0; offset_in = 32'h0; store_data = 32'h0; dest_in = 4'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    last_dest = 4'h0; last_data = 32'h0;
    exp_addr = 32'h0; exp_be = 4'h0; exp_we = 1'b0; exp_wdata = 32'h0;
    set_exp(0, 0, 0, 0, 0);
    exp_mem_vld = 1'b1;
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_mem_vld = 1'b0;

    // Word store, ack in the third REQ cycle.
    run_txn(0, 2'b10, 0, 32'h1000, 32'h8, 32'hDEAD_BEEF, 4'h0, 32'h0, 2, wb, nreq, ft, a, wd, be);
    check("st_word_addr", a, 32'h0000_1008);
    check("st_word_be", 32'(be), 32'hF);
    check("st_word_wdata", wd, 32'hDEAD_BEEF);
    check("st_word_req_cycles", 32'(nreq), 32'd3);

    // Byte loads at ea 0x2003, signed then unsigned.
    run_txn(1, 2'b00, 1, 32'h2000, 32'h3, 32'h0, 4'h5, 32'h80FF_1234, 0, wb, nreq, ft, a, wd, be);
    check("ld_byte_sx", wb, 32'hFFFF_FF80);
    check("ld_byte_dest", 32'(wb_dest), 32'h5);
    check("ld_byte_be", 32'(be), 32'h8);
    run_txn(1, 2'b00, 0, 32'h2000, 32'h3, 32'h0, 4'h5, 32'h80FF_1234, 1, wb, nreq, ft, a, wd, be);
    check("ld_byte_zx", wb, 32'h0000_0080);

    // Halfword store then load at ea 0x2002.
    run_txn(0, 2'b01, 0, 32'h2000, 32'h2, 32'h0000_ABCD, 4'h0, 32'h0, 0, wb, nreq, ft, a, wd, be);
    check("st_half_be", 32'(be), 32'hC);
    check("st_half_wdata", wd, 32'hABCD_ABCD);
    run_txn(1, 2'b01, 0, 32'h2000, 32'h2, 32'h0, 4'h9, 32'hABCD_0000, 0, wb, nreq, ft, a, wd, be);
    check("ld_half_zx", wb, 32'h0000_ABCD);

    // Timeout with no ack, then ack landing on the final allowed cycle.
    run_txn(1, 2'b10, 0, 32'h40, 32'h0, 32'h0, 4'h3, 32'h0, 100, wb, nreq, ft, a, wd, be);
    check("to_fault", 32'(ft), 32'h1);
    check("to_req_cycles", 32'(nreq), 32'd4);
    run_txn(1, 2'b10, 0, 32'h40, 32'h0, 32'h0, 4'h3, 32'h1234_5678, 3, wb, nreq, ft, a, wd, be);
    check("to_edge_fault", 32'(ft), 32'h0);
    check("to_edge_data", wb, 32'h1234_5678);

    // Misaligned word load at ea 0x1002.
    run_txn(1, 2'b10, 0, 32'h1000, 32'h2, 32'h0, 4'h1, 32'hCAFE_F00D, 0, wb, nreq, ft, a, wd, be);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_fault", 32'(ft), 32'h1);
    check("mis_req_cycles", 32'(nreq), 32'd0);
`else
    check("mis_addr", a, 32'h0000_1000);
    check("mis_be", 32'(be), 32'hF);
    check("mis_data", wb, 32'hCAFE_F00D);
`endif

    // Reset during REQ, then a late ack that must be ignored.
    start = 1'b1; is_load = 1'b1; size = 2'b10; base_in = 32'h300; offset_in = 32'h4;
    dest_in = 4'h7;
    step();
    start = 1'b1;
    set_exp(1, 1, 0, 0, 0);
    exp_mem_vld = 1'b1; exp_addr = 32'h304; exp_be = 4'hF; exp_we = 1'b0;
    exp_wdata = store_data;
    step();
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    set_exp(0, 0, 0, 0, 0);
    exp_addr = 32'h0; exp_be = 4'h0; exp_we = 1'b0; exp_wdata = 32'h0;
    last_dest = 4'h0; last_data = 32'h0;
    step();
    mem_ack = 1'b0;
    step();
    exp_mem_vld = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      ld  = 1'($urandom);
      sz  = 2'($urandom);
      dly = ($urandom_range(0, 5) == 0) ? 100 : int'($urandom_range(0, 4));
      run_txn(ld, sz, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), $urandom, dly,
              wb, nreq, ft, a, wd, be);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
